// File: rtl/dds_pkg.sv
// Shared constants and types for the DDS phase accumulator: register map,
// CTRL bit positions, register-bank layout and default widths.
package dds_pkg;

  localparam int DEF_ACC_W = 32;
  localparam int DEF_OUT_W = 8;

  localparam int FTW_W  = 32;
  localparam int POW_W  = 8;
  localparam int CTRL_W = 2;
  localparam int ADDR_W = 2;
  localparam int DATA_W = 16;

  typedef enum logic [ADDR_W-1:0] {
    ADDR_FTW_LO = 2'd0,
    ADDR_FTW_HI = 2'd1,
    ADDR_POW    = 2'd2,
    ADDR_CTRL   = 2'd3
  } reg_addr_e;

  // CTRL[0]: defer the transfer to the next accumulator carry-out.
  // CTRL[1]: zero the accumulator on the edge the transfer happens.
  localparam int CTRL_SYNC_BIT = 0;
  localparam int CTRL_CLR_BIT  = 1;

  typedef struct packed {
    logic [FTW_W-1:0]  ftw;
    logic [POW_W-1:0]  pow;
    logic [CTRL_W-1:0] ctrl;
  } dds_regs_t;

  typedef enum logic {
    ST_IDLE    = 1'b0,
    ST_PENDING = 1'b1
  } commit_state_e;

endpackage

// File: rtl/dds_shadow_regs.sv
// Shadow register bank written by the SPI slave; the accumulator only ever
// sees these values after a commit copies them into the active set.
module dds_shadow_regs
  import dds_pkg::*;
(
  input  logic              clk,
  input  logic              rst,
  input  logic              wr_en,
  input  logic [ADDR_W-1:0] wr_addr,
  input  logic [DATA_W-1:0] wr_data,
  output dds_regs_t         shadow
);

  // NOTE: sequential state is assigned with <= only, so every flop samples
  // the pre-edge value of every other flop regardless of block ordering.
  always_ff @(posedge clk) begin
    if (rst) begin
      shadow <= '0;
    end else if (wr_en) begin
      unique case (reg_addr_e'(wr_addr))
        ADDR_FTW_LO: shadow.ftw[15:0]  <= wr_data;
        ADDR_FTW_HI: shadow.ftw[31:16] <= wr_data;
        ADDR_POW:    shadow.pow        <= wr_data[POW_W-1:0];
        ADDR_CTRL:   shadow.ctrl       <= wr_data[CTRL_W-1:0];
      endcase
    end
  end

endmodule

// File: rtl/dds_phase_accum.sv
// DDS phase accumulator with double-buffered tuning registers; a commit
// transfers them either immediately or on the next accumulator carry-out.
module dds_phase_accum
  import dds_pkg::*;
#(
  parameter int ACC_W = DEF_ACC_W,
  parameter int OUT_W = DEF_OUT_W
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              en,
  input  logic              wr_en,
  input  logic [ADDR_W-1:0] wr_addr,
  input  logic [DATA_W-1:0] wr_data,
  input  logic              commit,
  output logic [OUT_W-1:0]  phase_out,
  output logic              phase_valid,
  output logic              wrap,
  output logic              pending
);

  dds_regs_t     shadow;
  dds_regs_t     active;
  commit_state_e state, state_nxt;

  logic [ACC_W-1:0] acc, acc_nxt;
  logic [ACC_W:0]   sum;
  logic [OUT_W-1:0] phase_nxt;
  logic             carry;
  logic             commit_sync;
  logic             imm_apply;
  logic             sync_apply;
  logic             apply;
  logic             clr_now;
  logic             pend_clr, pend_clr_nxt;

  dds_shadow_regs u_shadow (
    .clk     (clk),
    .rst     (rst),
    .wr_en   (wr_en),
    .wr_addr (wr_addr),
    .wr_data (wr_data),
    .shadow  (shadow)
  );

  // NOTE: every signal written here gets a default first, so no path through
  // the block can leave a value unassigned and infer a latch.
  always_comb begin
    sum          = {1'b0, acc} + {1'b0, ACC_W'(active.ftw)};
    carry        = en & sum[ACC_W];
    commit_sync  = commit & shadow.ctrl[CTRL_SYNC_BIT];
    imm_apply    = commit & ~shadow.ctrl[CTRL_SYNC_BIT];
    sync_apply   = (state == ST_PENDING) & carry;
    apply        = imm_apply | sync_apply;
    clr_now      = imm_apply ? shadow.ctrl[CTRL_CLR_BIT] : pend_clr;
    state_nxt    = state;
    pend_clr_nxt = pend_clr;
    acc_nxt      = acc;

    // A sync commit latches clr_on_apply now; the CTRL write that follows
    // must not change what the eventual apply does.
    if (commit_sync) pend_clr_nxt = shadow.ctrl[CTRL_CLR_BIT];

    unique case (state)
      ST_IDLE:    if (commit_sync) state_nxt = ST_PENDING;
      ST_PENDING: if (apply)       state_nxt = ST_IDLE;
    endcase

    // With en low the accumulator holds even across an immediate apply;
    // the clear only takes effect on an edge that would have advanced it.
    if (en) acc_nxt = (apply && clr_now) ? '0 : sum[ACC_W-1:0];

    phase_nxt = acc_nxt[ACC_W-1 -: OUT_W] + OUT_W'(active.pow);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state       <= ST_IDLE;
      pend_clr    <= 1'b0;
      active      <= '0;
      acc         <= '0;
      phase_out   <= '0;
      phase_valid <= 1'b0;
      wrap        <= 1'b0;
    end else begin
      state       <= state_nxt;
      pend_clr    <= pend_clr_nxt;
      acc         <= acc_nxt;
      phase_valid <= en;
      wrap        <= carry;
      if (apply) active    <= shadow;
      if (en)    phase_out <= phase_nxt;
    end
  end

  assign pending = (state == ST_PENDING);

endmodule
